core_sram_slave: RTL

On-chip SRAM responder implementing the slave end of the core memory interface (req/gnt/rvalid protocol). It accepts pipelined instruction or data requests from an Ibex-style master, performs byte-enabled word writes and word reads, and returns each response after a fixed, configurable latency. Out-of-range accesses are flagged with `err`. It serves as the local boot/scratch memory and as the slave-side model for exercising core masters without a Wishbone fabric.

---
 rtl/core_sram_slave.sv | 89 ++++++++
 1 files changed

// File: rtl/core_sram_slave.sv
// On-chip SRAM responder for the core req/gnt/rvalid memory protocol.
// Byte-enabled word writes, word reads, fixed-latency in-order responses with range error.
module core_sram_slave #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned WAIT_STATES     = 0,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        gnt,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned AW      = $clog2(MEM_WORDS);
  localparam int unsigned STAGES  = 1 + WAIT_STATES;
  localparam logic [2:0]  MAX_CNT = 3'(MAX_OUTSTANDING);

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] idx;
  logic          in_range;
  logic          accept;
  logic [2:0]    pending;
  logic [2:0]    in_flight;
  logic          vld_p  [STAGES];
  logic          err_p  [STAGES];
  logic [31:0]   data_p [STAGES];
  logic          unused_bits;

  // BASE_ADDR is aligned to the memory size, so the upper address bits alone decide the range.
  assign idx         = addr[AW+1:2];
  assign in_range    = (addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign in_flight   = pending - {2'b00, rvalid};
  assign gnt         = req && !rst && (in_flight < MAX_CNT);
  assign accept      = gnt;
  assign unused_bits = ^addr[1:0];

  assign rvalid = vld_p[STAGES-1];
  assign err    = err_p[STAGES-1];
  assign rdata  = data_p[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (accept && !rvalid) begin
      pending <= pending + 3'd1;
    end else if (!accept && rvalid) begin
      pending <= pending - 3'd1;
    end
  end

  // Write commit at the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k]  <= 1'b0;
        err_p[k]  <= 1'b0;
        data_p[k] <= '0;
      end
    end else begin
      // Stage 0: capture response at the accept edge (read sees earlier writes only).
      vld_p[0]  <= accept;
      err_p[0]  <= accept && !in_range;
      data_p[0] <= (accept && in_range && !we) ? mem[idx] : '0;
      // Stages 1..WAIT_STATES: pure delay line.
      for (int k = 1; k < STAGES; k++) begin
        vld_p[k]  <= vld_p[k-1];
        err_p[k]  <= err_p[k-1];
        data_p[k] <= data_p[k-1];
      end
    end
  end

endmodule
